// File: rtl/uart_pkg.sv
// uart_pkg: parity modes and frame-FSM states shared by the UART transmitter and receiver.
package uart_pkg;
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous first-word-fall-through FIFO with full/empty/level, shared by TX and RX.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     sysclk_in,
    input  logic                     rst_in,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = level == (AW+1)'(DEPTH);
    assign empty   = level == '0;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge sysclk_in or posedge rst_in)
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    // Storage needs no reset: flushing is done by clearing the pointers.
    always_ff @(posedge sysclk_in)
        if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: FIFO-fed UART transmitter with configurable data width, parity and stop bits,
// timed by an oversampled baud pulse; frames go out back-to-back while words are queued.
module uart_tx_frame import uart_pkg::*; #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int OVERSAMPLING = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            sysclk_in,
    input  logic                            rst_in,
    input  logic                            baudpulse_in,
    input  logic                            tx_valid_in,
    input  logic [DATA_BITS-1:0]            tx_data_in,
    output logic                            tx_ready_out,
    output logic                            tx_serial_out,
    output logic                            tx_busy_out,
    output logic                            tx_done_out,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level_out
);
    localparam int TW = $clog2(OVERSAMPLING);
    localparam int BW = $clog2(DATA_BITS) + 1;
    state_t state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, fifo_dout;
    logic par_q, par_d, load, done_d, serial_d, full, empty, tick_end;
    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .sysclk_in (sysclk_in),
        .rst_in    (rst_in),
        .push      (tx_valid_in),
        .pop       (load),
        .din       (tx_data_in),
        .dout      (fifo_dout),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level_out)
    );
    assign tx_ready_out = !full;
    assign tick_end = baudpulse_in && tick_q == TW'(OVERSAMPLING - 1);
    always_comb begin
        state_d = state_q;
        tick_d  = baudpulse_in ? (tick_end ? '0 : tick_q + 1'b1) : tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        load    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (baudpulse_in && !empty) begin
                    load    = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: if (tick_end) state_d = S_DATA;
            S_DATA: if (tick_end) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 1'b1;
                if (bit_q == BW'(DATA_BITS - 1)) begin
                    bit_d   = '0;
                    state_d = PARITY != PAR_NONE ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: if (tick_end) state_d = S_STOP;
            S_STOP: if (tick_end) begin
                bit_d = bit_q + 1'b1;
                if (bit_q == BW'(STOP_BITS - 1)) begin
                    bit_d   = '0;
                    done_d  = 1'b1;
                    load    = !empty;
                    state_d = empty ? S_IDLE : S_START;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Parity is taken from the whole word at load, before shifting destroys it.
        if (load) begin
            shift_d = fifo_dout;
            par_d   = PARITY == PAR_EVEN ? ^fifo_dout : ~^fifo_dout;
            tick_d  = '0;
            bit_d   = '0;
        end
        serial_d = state_d == S_START  ? 1'b0 :
                   state_d == S_DATA   ? shift_d[0] :
                   state_d == S_PARITY ? par_d : 1'b1;
    end
    always_ff @(posedge sysclk_in or posedge rst_in)
        if (rst_in) begin
            state_q       <= S_IDLE;
            tick_q        <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            tx_serial_out <= 1'b1;
            tx_busy_out   <= 1'b0;
            tx_done_out   <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            tx_serial_out <= serial_d;
            tx_busy_out   <= state_d != S_IDLE;
            tx_done_out   <= done_d;
        end
endmodule
